// File: rtl/toggle_debounce.sv
// Purpose : debounce a raw push-button and emit a one-cycle toggle pulse per accepted press.
// Latency : t rises STABLE_CNT+2 edges after btn_in goes high (2 sync + STABLE_CNT qualify).
// Backpr. : none; en gates the pulse at the acceptance edge and a gated press is dropped.
//
// Ports:
//   clk       - single clock, all state on posedge
//   reset     - asynchronous active-low reset
//   btn_in    - raw asynchronous button level (may bounce)
//   en        - toggle-pulse enable, sampled at the press-acceptance edge
//   t         - registered one-cycle toggle pulse for a downstream T flip-flop
//   btn_level - registered debounced button level
//   busy      - high while a candidate level change is being qualified
module toggle_debounce #(
  parameter int STABLE_CNT = 8,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic en,
  output logic t,
  output logic btn_level,
  output logic busy
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] PRESSED   = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_meta_q, sync_meta_d;
  logic             btn_sync_q,  btn_sync_d;
  logic [1:0]       state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             t_q,         t_d;
  logic             btn_level_q, btn_level_d;
  logic             busy_q,      busy_d;

  always_comb begin
    sync_meta_d = btn_in;
    btn_sync_d  = sync_meta_q;
    state_d     = state_q;
    cnt_d       = '0;
    t_d         = 1'b0;

    // The counter holds the number of consecutive matching samples seen so
    // far in a WAIT state; it stops at CNT_LAST because that sample commits
    // the transition, so it can never exceed STABLE_CNT-1 or wrap.
    case (state_q)
      IDLE: begin
        if (btn_sync_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!btn_sync_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          // Pulse only if enabled at this very edge; a gated press is lost.
          t_d     = en;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_sync_q) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (btn_sync_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register on the same
    // edge as the state itself.
    btn_level_d = (state_d == PRESSED)   || (state_d == WAIT_LOW);
    busy_d      = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta_q <= 1'b0;
      btn_sync_q  <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      t_q         <= 1'b0;
      btn_level_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync_meta_q <= sync_meta_d;
      btn_sync_q  <= btn_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      t_q         <= t_d;
      btn_level_q <= btn_level_d;
      busy_q      <= busy_d;
    end
  end

  assign t         = t_q;
  assign btn_level = btn_level_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_toggle_debounce.sv
// Purpose : directed self-checking bench for toggle_debounce (default parameters).
// Latency : samples outputs 1 ns after each rising edge; inputs change at the same point.
// Backpr. : n/a; every wait is a fixed cycle count.
module tb_toggle_debounce;

  logic clk;
  logic reset;
  logic btn_in;
  logic en;
  logic t;
  logic btn_level;
  logic busy;

  int checks = 0;
  int errors = 0;

  // Free-running observers: pulse count, debounced-level-high count and a
  // downstream toggle flip-flop driven by t.
  int   pulse_cnt = 0;
  int   level_cnt = 0;
  logic tff_q;

  toggle_debounce #(
    .STABLE_CNT(8),
    .CNT_W     (4)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (btn_in),
    .en       (en),
    .t        (t),
    .btn_level(btn_level),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (t)         pulse_cnt <= pulse_cnt + 1;
    if (btn_level) level_cnt <= level_cnt + 1;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset)  tff_q <= 1'b0;
    else if (t)  tff_q <= ~tff_q;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Press-accept timing: btn_in rises before edge 0; after n ticks the bench
  // sits in the cycle following edge n-1.
  task automatic press_and_check(input string tag, input logic exp_pulse);
    int e;
    btn_in = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick(1);
      e = n - 1;
      check({tag, "_t"},     int'(t),         (exp_pulse && e == 9) ? 1 : 0);
      check({tag, "_level"}, int'(btn_level), (e >= 9) ? 1 : 0);
      check({tag, "_busy"},  int'(busy),      (e >= 2 && e <= 8) ? 1 : 0);
    end
  endtask

  task automatic release_and_check(input string tag);
    int e;
    btn_in = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick(1);
      e = n - 1;
      check({tag, "_t"},     int'(t),         0);
      check({tag, "_level"}, int'(btn_level), (e < 9) ? 1 : 0);
      check({tag, "_busy"},  int'(busy),      (e >= 2 && e <= 8) ? 1 : 0);
    end
  endtask

  initial begin
    int p0;
    int l0;

    reset  = 1'b0;
    btn_in = 1'b0;
    en     = 1'b1;

    // Reset state, before any clock edge.
    #2;
    check("rst_t",     int'(t),         0);
    check("rst_level", int'(btn_level), 0);
    check("rst_busy",  int'(busy),      0);
    tick(3);
    reset = 1'b1;
    tick(2);
    check("idle_busy", int'(busy), 0);

    // Clean press with en=1, then hold: exactly one pulse, no auto-repeat.
    p0 = pulse_cnt;
    press_and_check("press", 1'b1);
    tick(20);
    check("hold_pulses", pulse_cnt - p0, 1);
    check("hold_level",  int'(btn_level), 1);

    // Release from PRESSED.
    p0 = pulse_cnt;
    release_and_check("rel");
    check("rel_pulses", pulse_cnt - p0, 0);
    tick(4);

    // Bounce: high 3, low 2, high 3, then low -- never accepted.
    p0 = pulse_cnt;
    l0 = level_cnt;
    btn_in = 1'b1; tick(3);
    btn_in = 1'b0; tick(2);
    btn_in = 1'b1; tick(3);
    btn_in = 1'b0; tick(12);
    check("bounce_pulses", pulse_cnt - p0, 0);
    check("bounce_level",  level_cnt - l0, 0);
    check("bounce_busy",   int'(busy), 0);

    // en gating: gated press is dropped, raising en while held gives nothing.
    p0 = pulse_cnt;
    en = 1'b0;
    press_and_check("gated", 1'b0);
    en = 1'b1;
    tick(6);
    check("gated_pulses", pulse_cnt - p0, 0);
    release_and_check("gated_rel");
    tick(4);
    p0 = pulse_cnt;
    press_and_check("repress", 1'b1);
    check("repress_pulses", pulse_cnt - p0, 1);
    release_and_check("repress_rel");
    tick(4);

    // Async reset in WAIT_HIGH, between edges, with the button held.
    btn_in = 1'b1;
    tick(5);
    check("wh_busy", int'(busy), 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_t",     int'(t),         0);
    check("arst_level", int'(btn_level), 0);
    check("arst_busy",  int'(busy),      0);
    tick(2);
    #2;
    reset = 1'b1;
    p0 = pulse_cnt;
    tick(9);
    check("arst_t_e8", int'(t), 0);
    tick(1);
    check("arst_t_e9", int'(t), 1);
    check("arst_lvl",  int'(btn_level), 1);
    tick(1);
    check("arst_t_e10", int'(t), 0);
    tick(10);
    check("arst_pulses", pulse_cnt - p0, 1);
    btn_in = 1'b0;
    tick(14);

    // Chained toggle flip-flop: 5 clean presses.
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(2);
    p0 = pulse_cnt;
    for (int k = 0; k < 5; k++) begin
      btn_in = 1'b1; tick(14);
      btn_in = 1'b0; tick(14);
    end
    check("tff_toggles", pulse_cnt - p0, 5);
    check("tff_q",       int'(tff_q), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/toggle_debounce.md
TOGGLE_DEBOUNCE -- requirements
Module: toggle_debounce

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 8, number of consecutive synchronized samples needed to accept a level change; legal range 2..2**CNT_W-1.
REQ-002 SHALL have parameter CNT_W, default 4, debounce counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port btn_in  input  1  raw asynchronous push-button level; may bounce.
REQ-006 SHALL have port en  input  1  toggle-pulse enable.
REQ-007 SHALL have port t  output  1  registered one-cycle toggle pulse; drives the T input of the downstream toggle flip-flop.
REQ-008 SHALL have port btn_level  output  1  registered debounced button level.
REQ-009 SHALL have port busy  output  1  high while a candidate level change is being qualified.

Function
REQ-010 SHALL pass btn_in through a 2-flop synchronizer; btn_sync is the second flop, and only btn_sync feeds the FSM.
REQ-011 SHALL implement FSM states IDLE (level 0), WAIT_HIGH, PRESSED (level 1), WAIT_LOW.
REQ-012 IDLE: btn_sync=1 -> WAIT_HIGH, cnt=1; else stay, cnt=0.
REQ-013 WAIT_HIGH: btn_sync=0 -> IDLE, cnt=0; btn_sync=1 and cnt==STABLE_CNT-1 -> PRESSED, cnt=0; else cnt+1.
REQ-014 PRESSED: btn_sync=0 -> WAIT_LOW, cnt=1; else stay, cnt=0.
REQ-015 WAIT_LOW: btn_sync=1 -> PRESSED, cnt=0; btn_sync=0 and cnt==STABLE_CNT-1 -> IDLE, cnt=0; else cnt+1.
REQ-016 t SHALL be 1 for exactly the one cycle following the WAIT_HIGH->PRESSED transition edge, and only if en=1 at that edge; otherwise 0.
REQ-017 A press accepted while en=0 SHALL produce no t pulse; the pulse SHALL NOT be deferred or queued to a later en=1.
REQ-018 The release path (WAIT_LOW->IDLE) SHALL never assert t.
REQ-019 btn_level SHALL be 1 in PRESSED and WAIT_LOW and 0 in IDLE and WAIT_HIGH, updated on the same edge as the state.
REQ-020 busy SHALL be 1 exactly in WAIT_HIGH and WAIT_LOW.
REQ-021 Latency: btn_in stable high from before edge k SHALL give t=1 in the cycle after edge k+STABLE_CNT+1 (10 cycles for default STABLE_CNT).
REQ-022 Any btn_sync glitch shorter than STABLE_CNT samples SHALL return the FSM to its prior stable state with no t pulse and no btn_level change.
REQ-023 cnt SHALL never exceed STABLE_CNT-1 and SHALL never wrap.
REQ-024 Holding the button continuously SHALL produce exactly one t pulse per accepted press (no auto-repeat).

Reset
REQ-025 reset=0 SHALL immediately, without a clock, force both synchronizer flops to 0, state=IDLE, cnt=0, t=0, btn_level=0, busy=0.
REQ-026 Reset asserted mid-qualification SHALL discard the pending press; after release, a still-held button SHALL be re-qualified from IDLE and produce one t pulse.
REQ-027 After reset deassertion, the first state update SHALL occur at the next posedge clk.

Verification
REQ-028 Clean press: btn_in 0->1 before edge 0, held, en=1 -> t=1 only in the cycle after edge 9, btn_level=1 from the same edge, busy high for the cycles after edges 2..8.
REQ-029 Bounce: btn_in high 3 cycles, low 2 cycles, high 3 cycles, then low -> t stays 0, btn_level stays 0.
REQ-030 en gating: a press accepted while en=0 -> t=0 throughout; raising en while still held -> still no pulse; release and re-press with en=1 -> one pulse.
REQ-031 Release: from PRESSED, drop btn_in for at least 10 cycles -> btn_level falls to 0 after STABLE_CNT+2 edges, t=0 throughout.
REQ-032 Async reset: assert reset between clock edges during WAIT_HIGH -> all outputs 0 immediately; release with the button held -> exactly one t pulse 10 edges later.
REQ-033 Chained check: drive t into a toggle flip-flop with 5 clean presses -> flip-flop q toggles 5 times and ends at 1.
